// File: rtl/flexpipe_pkg.sv
// flexpipe_pkg
// Shared types and widths for the accelerator memory interface.
//   mem_req_t  : {addr, we, wdata, id}   request from the memory arbiter
//   mem_resp_t : {rdata, id, err}        in-order response to the arbiter
// BYTE_OFF is the number of address bits that select a byte inside a word.
package flexpipe_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int BYTE_OFF   = $clog2(DATA_WIDTH / 8);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [DATA_WIDTH-1:0] wdata;
        logic [ID_WIDTH-1:0]   id;
    } mem_req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic [ID_WIDTH-1:0]   id;
        logic                  err;
    } mem_resp_t;

endpackage

// File: rtl/dram_resp_pipe.sv
// dram_resp_pipe
// LATENCY-deep shift pipeline carrying a valid bit and a response payload.
// Stage 0 loads every cycle; the last stage drives the outputs directly, so
// the outputs are purely registered.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all stages)
//   valid_i    : stage-0 valid (a request was accepted this cycle)
//   data_i     : stage-0 payload
//   valid_o    : last-stage valid (one-cycle response strobe)
//   data_o     : last-stage payload
module dram_resp_pipe
    import flexpipe_pkg::*;
#(
    parameter int LATENCY = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      valid_i,
    input  mem_resp_t data_i,
    output logic      valid_o,
    output mem_resp_t data_o
);

    logic [LATENCY-1:0] valid_q;
    mem_resp_t          data_q [LATENCY];

    // Reset clears the valids so in-flight responses are dropped, and clears
    // the payloads so the response bus reads as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/dram_responder.sv
// dram_responder
// Memory-side responder for the accelerator's master DRAM port. Accepts
// requests, accesses an internal word array at the accept edge and answers
// each request with one in-order response exactly LATENCY cycles later.
// Optional feature macro: DRAM_RESP_REFRESH_EN (periodic refresh windows
// during which mem_ready is held low).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   mem_req        : request {addr, we, wdata, id}
//   mem_valid      : request valid
//   mem_ready      : responder can accept (registered state only)
//   mem_resp       : response {rdata, id, err}
//   mem_resp_valid : one-cycle response strobe, no backpressure
//   stat_reads     : saturating count of accepted reads
//   stat_writes    : saturating count of accepted writes
module dram_responder
    import flexpipe_pkg::*;
#(
    parameter int DEPTH           = 4096,
    parameter int LATENCY         = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int REFRESH_PERIOD  = 512,
    parameter int REFRESH_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  mem_req_t    mem_req,
    input  logic        mem_valid,
    output logic        mem_ready,
    output mem_resp_t   mem_resp,
    output logic        mem_resp_valid,
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes
);

    localparam int                    IDX_W   = $clog2(DEPTH);
    localparam int                    CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    logic                  accept;
    logic                  refreshActive;
    logic                  inRange;
    logic [ADDR_WIDTH-1:0] wordIdx;
    logic [IDX_W-1:0]      memIdx;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]      count_q, count_d;
    logic [31:0]           reads_q, writes_q;
    mem_resp_t             stage0;

    // Address decode: the full shifted address is range-checked so high
    // address bits cannot alias into the array.
    assign wordIdx = mem_req.addr >> BYTE_OFF;
    assign inRange = wordIdx < DEPTH_A;
    assign memIdx  = wordIdx[IDX_W-1:0];

    // Ready is built only from registers, keeping mem_valid out of its cone.
    assign mem_ready = (count_q < MAX_CNT) && !refreshActive;
    assign accept    = mem_valid && mem_ready;

    // Stage-0 payload. Read data is captured now, so a later write to the
    // same word cannot change an in-flight read. Writes and out-of-range
    // requests return zero data.
    always_comb begin
        stage0.rdata = '0;
        stage0.id    = mem_req.id;
        stage0.err   = !inRange;
        if (accept && !mem_req.we && inRange) begin
            stage0.rdata = mem_q[memIdx];
        end
    end

    // Storage: zeroed by reset, written at the accept edge when in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept && mem_req.we && inRange) begin
            mem_q[memIdx] <= mem_req.wdata;
        end
    end

    dram_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (accept),
        .data_i  (stage0),
        .valid_o (mem_resp_valid),
        .data_o  (mem_resp)
    );

    // Outstanding count: an accept and a response in the same cycle cancel.
    always_comb begin
        count_d = count_q;
        case ({accept, mem_resp_valid})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Saturating statistics; out-of-range requests still count as accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reads_q  <= '0;
            writes_q <= '0;
        end else if (accept) begin
            if (!mem_req.we && (reads_q != 32'hFFFF_FFFF)) begin
                reads_q <= reads_q + 32'd1;
            end
            if (mem_req.we && (writes_q != 32'hFFFF_FFFF)) begin
                writes_q <= writes_q + 32'd1;
            end
        end
    end

    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;

`ifdef DRAM_RESP_REFRESH_EN
    localparam int               PER_W    = $clog2(REFRESH_PERIOD);
    localparam int               WIN_W    = $clog2(REFRESH_CYCLES + 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(REFRESH_PERIOD - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(REFRESH_CYCLES - 1);

    logic [PER_W-1:0] period_q;
    logic [WIN_W-1:0] window_q;
    logic             refresh_q;

    // The period counter free-runs from reset; its wrap opens a window that
    // stays open for REFRESH_CYCLES cycles. The first wrap lands exactly
    // REFRESH_PERIOD cycles after reset. The pipeline is untouched, so
    // in-flight responses keep draining during the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q  <= '0;
            window_q  <= '0;
            refresh_q <= 1'b0;
        end else begin
            period_q <= (period_q == PER_LAST) ? '0 : period_q + PER_W'(1);
            if (period_q == PER_LAST) begin
                refresh_q <= 1'b1;
                window_q  <= '0;
            end else if (refresh_q) begin
                if (window_q == WIN_LAST) begin
                    refresh_q <= 1'b0;
                end else begin
                    window_q <= window_q + WIN_W'(1);
                end
            end
        end
    end

    assign refreshActive = refresh_q;
`else
    logic unusedRefreshCfg;

    // Refresh timing parameters have no effect without refresh support.
    assign unusedRefreshCfg = ^{REFRESH_PERIOD, REFRESH_CYCLES};
    assign refreshActive    = 1'b0;
`endif

endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder
// Self-checking bench for dram_responder. A stimulus process issues
// directed and random requests; a negedge monitor keeps a behavioural memory
// model, pushes the expected response for every accept into a scoreboard
// queue and pops/compares whenever mem_resp_valid is seen.
module tb_dram_responder;
    import flexpipe_pkg::*;

    localparam int DEPTH   = 4096;
    localparam int LATENCY = 8;
    localparam int MAXO    = 4;
    localparam int RPER    = 512;
    localparam int RCYC    = 16;

    typedef struct {
        logic [31:0] rdata;
        logic [3:0]  id;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    mem_req_t    mem_req = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    mem_resp_t   mem_resp;
    logic        mem_resp_valid;
    logic [31:0] stat_reads, stat_writes;

    exp_t        sbq[$];
    logic [31:0] model[int];
    int          modelReads = 0;
    int          modelWrites = 0;
    int          cyc = 0;
    int          sinceRst = 0;
    int          errors = 0;
    int          checks = 0;
    bit          accNow = 0;

    dram_responder #(
        .DEPTH           (DEPTH),
        .LATENCY         (LATENCY),
        .MAX_OUTSTANDING (MAXO),
        .REFRESH_PERIOD  (RPER),
        .REFRESH_CYCLES  (RCYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_resp       (mem_resp),
        .mem_resp_valid (mem_resp_valid),
        .stat_reads     (stat_reads),
        .stat_writes    (stat_writes)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Edge counters: absolute, and since the last reset release.
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sinceRst <= 0;
        else        sinceRst <= sinceRst + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor and reference model. Runs on the falling edge, where the DUT
    // outputs are stable and the inputs for the next rising edge are set.
    always @(negedge clk) begin
        exp_t e;
        bit   refr;
        int   idx;
        accNow = 0;
        if (!rst_n) begin
            checkOutput("resp_valid_in_reset", 32'(mem_resp_valid), 32'd0);
        end else begin
`ifdef DRAM_RESP_REFRESH_EN
            refr = (sinceRst >= RPER) && ((sinceRst % RPER) < RCYC);
`else
            refr = 0;
`endif
            checkOutput("stat_reads", stat_reads, 32'(modelReads));
            checkOutput("stat_writes", stat_writes, 32'(modelWrites));
            checkOutput("mem_ready", 32'(mem_ready), 32'((sbq.size() < MAXO) && !refr));
            if (mem_resp_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_resp: actual valid=1 id=%0d required no response", mem_resp.id);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("resp_rdata", mem_resp.rdata, e.rdata);
                    checkOutput("resp_id", 32'(mem_resp.id), 32'(e.id));
                    checkOutput("resp_err", 32'(mem_resp.err), 32'(e.err));
                    checkOutput("resp_latency", 32'(cyc), 32'(e.due));
                end
            end
            if (mem_valid && mem_ready) begin
                // Accept happens at the coming rising edge, so the response
                // is visible at the falling edge LATENCY cycles from now.
                accNow = 1;
                idx    = int'(mem_req.addr >> 2);
                e.id   = mem_req.id;
                e.due  = cyc + LATENCY;
                e.err  = (mem_req.addr >> 2) >= DEPTH;
                e.rdata = '0;
                if (mem_req.we) modelWrites++;
                else            modelReads++;
                if (!e.err) begin
                    if (mem_req.we)             model[idx] = mem_req.wdata;
                    else if (model.exists(idx)) e.rdata = model[idx];
                end
                sbq.push_back(e);
            end
        end
    end

    // Present one request and hold it until accepted; returns 2 ns after the
    // accepting edge with the request still on the bus.
    task automatic applyStimulus(input logic [31:0] addr, input logic we,
                                 input logic [31:0] wdata, input logic [3:0] id);
        int n = 0;
        mem_req.addr  = addr;
        mem_req.we    = we;
        mem_req.wdata = wdata;
        mem_req.id    = id;
        mem_valid     = 1'b1;
        forever begin
            @(posedge clk);
            if (accNow) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: actual no accept in %0d cycles required accept", n);
                break;
            end
        end
        #2;
    endtask

    task automatic idle(input int n);
        mem_valid = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n = 0;
        mem_valid = 1'b0;
        while (sbq.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: actual %0d pending required 0", sbq.size());
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] a;
        $display("[TB] start");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Reset state.
        checkOutput("reset_resp", 32'(mem_resp), 32'd0);
        checkOutput("reset_valid", 32'(mem_resp_valid), 32'd0);
        checkOutput("reset_ready", 32'(mem_ready), 32'd1);

        // Write then read back the same word.
        applyStimulus(32'h40, 1'b1, 32'hA5A5_0001, 4'd3);
        idle(1);
        applyStimulus(32'h40, 1'b0, 32'h0, 4'd4);
        drain();

        // Eight back-to-back reads against the outstanding limit.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'(i * 4) + 32'h40, 1'b0, 32'h0, 4'(i));
        end
        drain();

        // Read followed immediately by a write to the same word.
        applyStimulus(32'h40, 1'b0, 32'h0, 4'd5);
        applyStimulus(32'h40, 1'b1, 32'h0000_FFFF, 4'd6);
        applyStimulus(32'h40, 1'b0, 32'h0, 4'd7);
        drain();

        // Out-of-range accesses, then confirm storage is intact.
        applyStimulus(32'(DEPTH * 4), 1'b0, 32'h0, 4'd9);
        applyStimulus(32'(DEPTH * 4), 1'b1, 32'hDEAD_BEEF, 4'd10);
        applyStimulus(32'hFFFF_FFFC, 1'b0, 32'h0, 4'd11);
        applyStimulus(32'h0, 1'b0, 32'h0, 4'd12);
        applyStimulus(32'h40, 1'b0, 32'h0, 4'd13);
        drain();

        // Randomized traffic over a small hot set plus some out-of-range.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 63) * 4);
            else                           a = 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            applyStimulus(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
        end
        drain();

        // Reset with three requests in flight.
        applyStimulus(32'h40, 1'b1, 32'h1234_5678, 4'd1);
        applyStimulus(32'h40, 1'b0, 32'h0, 4'd2);
        applyStimulus(32'h44, 1'b0, 32'h0, 4'd3);
        idle(1);
        rst_n = 1'b0;
        sbq.delete();
        model.delete();
        modelReads  = 0;
        modelWrites = 0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        checkOutput("post_reset_ready", 32'(mem_ready), 32'd1);
        checkOutput("post_reset_reads", stat_reads, 32'd0);
        checkOutput("post_reset_writes", stat_writes, 32'd0);
        idle(LATENCY + 4);
        applyStimulus(32'h40, 1'b0, 32'h0, 4'd8);
        drain();

`ifdef DRAM_RESP_REFRESH_EN
        // Continuous traffic across the first refresh window.
        while (sinceRst < RPER + RCYC + 12) begin
            if (sinceRst < RPER - 20) idle(1);
            else applyStimulus(32'($urandom_range(0, 15) * 4), 1'b0, 32'h0, 4'($urandom_range(0, 15)));
        end
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dram_responder.md
# dram_responder

Memory-side responder for the accelerator's master DRAM port. It accepts `mem_req_t` requests from the memory arbiter and answers every request with exactly one in-order `mem_resp_t` after a fixed latency, using an internal word array. It is the far end of the arbiter's master interface and replaces the behavioural DRAM model in system benches and FPGA bring-up.

## Interface
- `DEPTH`, 4096: storage size in DATA_WIDTH words (power of two).
- `LATENCY`, 8: cycles from request accept to response valid (≥1).
- `MAX_OUTSTANDING`, 4: accepted-but-unanswered request limit (1..LATENCY).
- `REFRESH_PERIOD`, 512: cycles between refresh windows (only with the refresh macro).
- `REFRESH_CYCLES`, 16: length of each refresh window (< REFRESH_PERIOD).
- Reset is `rst_n`, asynchronous, active-low; clock is `clk`.
- `clk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `mem_req` in `mem_req_t`: `{addr[ADDR_WIDTH], we, wdata[DATA_WIDTH], id[ID_WIDTH]}`.
- `mem_valid` in 1: request valid.
- `mem_ready` out 1: request accepted when `mem_valid && mem_ready`.
- `mem_resp` out `mem_resp_t`: `{rdata[DATA_WIDTH], id[ID_WIDTH], err}`.
- `mem_resp_valid` out 1: one-cycle response strobe; no backpressure.
- `stat_reads` out 32: count of accepted reads, saturating.
- `stat_writes` out 32: count of accepted writes, saturating.

## Operation
- Word index = `addr >> log2(DATA_WIDTH/8)`. If the index is ≥ DEPTH, the request is out of range.
- Read (`we=0`): data is sampled from storage at the accept edge. A later write to the same word does not change an in-flight read.
- Write (`we=1`): storage is updated at the accept edge. The response carries `rdata=0`.
- Out of range: no storage access. Response has `err=1` and `rdata='0`.
- Every response echoes the request `id`. Responses are strictly in accept order.
- Response pipeline: LATENCY stages, each holding `{valid, rdata, id, err}`. Stage 0 is loaded on accept. The last stage drives the outputs.
- Outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - +1 on accept, −1 on `mem_resp_valid`.
  - Accept and response in the same cycle leave it unchanged.
- `mem_ready = (count < MAX_OUTSTANDING) && !refresh_active`. It depends only on registered state; there is no combinational path from `mem_valid`.
- Stat counters increment on accept and hold at 0xFFFF_FFFF.

## Timing
- Reset values:
  - `mem_ready=1` (with refresh macro: 1, since the window starts closed).
  - `mem_resp_valid=0`, `mem_resp='0`.
  - Stats = 0, count = 0, all pipeline valids 0.
  - Storage zeroed.
- Accept at edge N → `mem_resp_valid` high in the cycle after edge N+LATENCY−1, i.e. sampled at edge N+LATENCY.
- Back-to-back accepts give back-to-back responses. Throughput is 1/cycle until count reaches MAX_OUTSTANDING.
- Count at MAX_OUTSTANDING: `mem_ready` is low. It rises in the cycle after the response that decrements the count.
- Reset mid-operation: in-flight responses are dropped (never emitted), count clears, storage clears.

## Configuration
- `DRAM_RESP_REFRESH_EN` defined:
  - A free-running period counter opens a refresh window for REFRESH_CYCLES cycles every REFRESH_PERIOD cycles. The first window opens REFRESH_PERIOD cycles after reset.
  - `mem_ready` is forced low during the window.
  - In-flight responses keep draining on schedule.
- Not defined: no refresh logic and `refresh_active` is constant 0.

## Structure
- `flexpipe_pkg` holds `mem_req_t`, `mem_resp_t`, `ADDR_WIDTH`, `DATA_WIDTH` and `ID_WIDTH`.
- `dram_responder` owns the counter, refresh and stats logic.
- One sub-module: `dram_resp_pipe`, the LATENCY-deep valid/payload shift pipeline.

## Test plan
- Write 0xA5A5_0001 to addr 0x40 id 3, then read addr 0x40 id 4 → two responses, each exactly LATENCY=8 cycles after its accept. The read returns rdata 0xA5A5_0001, id 4, err 0.
- Eight back-to-back reads with `mem_valid` held high, MAX_OUTSTANDING=4 → `mem_ready` drops after the 4th accept. Responses arrive in id order, and the 5th accept occurs the cycle after the 1st response.
- Read addr 0x40 accepted, then write 0xFFFF to 0x40 the next cycle → the read still returns the old value.
- Read addr DEPTH*4 (out of range) → `err=1`, `rdata=0`, storage unchanged; `stat_reads` increments.
- Assert `rst_n` low with 3 requests in flight → no `mem_resp_valid` after release, `mem_ready=1`, stats 0.
- With `DRAM_RESP_REFRESH_EN`, period 512 / window 16 → `mem_ready` is low for cycles 512..527 after reset, and responses accepted before cycle 512 still emit on schedule.
